seq_bw_mult_ctrl: RTL and testbench
===================================

SEQ_BW_MULT_CTRL -- requirements
Module: seq_bw_mult_ctrl

Interface
REQ-001 The block SHALL have parameter M, default 5, the operand width in bits (M >= 2).
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port start, input, 1 bit: request to multiply; sampled only in IDLE.
REQ-005 Port a, input, M bits: multiplicand, two's complement.
REQ-006 Port b, input, M bits: multiplier, two's complement.
REQ-007 Port busy, output, 1 bit: high while in RUN or DONE.
REQ-008 Port done, output, 1 bit: single-cycle pulse, high only in DONE.
REQ-009 Port p, output, 2M bits: signed product, two's complement.

Function
REQ-010 The block SHALL be a three-state FSM: IDLE, RUN, DONE.
REQ-011 IDLE with start=1 at an edge: go to RUN; capture a and b into internal registers; clear accumulator; set row counter to 0.
REQ-012 IDLE with start=0: stay in IDLE; p holds its value.
REQ-013 RUN: exactly one partial-product row per cycle. Row i is the bitwise AND of captured a with captured b[i]. The row is added to the accumulator left-shifted by i.
REQ-014 Baugh-Wooley sign handling, rows i < M-1: bit M-1 of the row SHALL be complemented before the add.
REQ-015 Baugh-Wooley sign handling, row M-1: bits 0..M-2 SHALL be complemented; bit M-1 is used as is.
REQ-016 Correction constant 2^M + 2^(2M-1) SHALL be added once. It is either preloaded into the accumulator at capture or added with the last row.
REQ-017 All accumulation SHALL be modulo 2^(2M), discarding the carry out of bit 2M-1.
REQ-018 The counter SHALL increment once per RUN cycle.
REQ-019 On the edge that adds row M-1: go to DONE and load p with the final accumulator value.
REQ-020 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-021 Latency: if start is accepted at edge t0, done SHALL be high in the cycle following edge t0+M.
REQ-022 p SHALL equal the exact signed product a*b for every input pair, including a = b = -2^(M-1).
REQ-023 start in RUN or DONE SHALL be ignored: no capture, no restart, no queuing.
REQ-024 A new start is accepted in the first IDLE cycle after DONE. Back-to-back throughput is one product per M+2 cycles.
REQ-025 Changes on a or b after capture SHALL NOT affect the result in progress.
REQ-026 p SHALL change only on the edge entering DONE. It holds the last product until the next completion.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force: state IDLE, busy=0, done=0, p=0, counter=0, accumulator=0, operand registers=0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation. No done pulse SHALL follow.
REQ-029 After rst_n deasserts, the first edge with start=1 SHALL be accepted normally.

Verification (M=5)
REQ-030 Reset, then start with a=7, b=-3 -> done high 5 edges after the start edge, p=10'h3EB (-21), busy high for 6 cycles.
REQ-031 a=-16, b=-16 -> p=10'h100 (256). a=-16, b=15 -> p=10'h310 (-240).
REQ-032 a=0, b=-1 -> p=0. a=-1, b=-1 -> p=1. a=15, b=15 -> p=10'h0E1 (225).
REQ-033 start held high continuously with new a/b each cycle -> one product per 7 cycles. Each p matches the a/b captured at its own start edge. Changes on a/b during RUN have no effect.
REQ-034 rst_n pulsed low during the third RUN cycle -> outputs zero asynchronously, no done pulse. The next start (a=3, b=2) -> p=6.
REQ-035 Exhaustive or random sweep of all 1024 a/b pairs -> every p equals the signed reference product modulo 2^10.

Source files
------------

// File: rtl/seq_bw_mult_ctrl_if.sv
// Handshake and operand/result bus for the sequential Baugh-Wooley multiplier.
interface seq_bw_mult_ctrl_if #(
  parameter int M = 5
);
  logic                  start;
  logic signed [M-1:0]   a;
  logic signed [M-1:0]   b;
  logic                  busy;
  logic                  done;
  logic signed [2*M-1:0] p;

  modport master (
    output start, a, b,
    input  busy, done, p
  );

  modport slave (
    input  start, a, b,
    output busy, done, p
  );
endinterface

// File: rtl/seq_bw_mult_ctrl.sv
// Sequential signed multiplier: one Baugh-Wooley partial-product row per cycle,
// IDLE -> RUN (M cycles) -> DONE (1 cycle) -> IDLE.
module seq_bw_mult_ctrl #(
  parameter int M = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_bw_mult_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(M + 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(M - 1);
  localparam logic [2*M-1:0]   ONE_P    = 1;
  localparam logic [2*M-1:0]   CORR     = (ONE_P << M) | (ONE_P << (2*M - 1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic signed [M-1:0]   a_q, b_q;
  logic        [2*M-1:0] acc_q;
  logic        [CNT_W-1:0] cnt_q;
  logic signed [2*M-1:0] p_q;

  logic                  last_row;
  logic        [2*M-1:0] row_shifted;
  logic        [2*M-1:0] acc_sum;

  // Sign handling: the last row inverts its low bits, every other row inverts its MSB.
  function automatic logic [M-1:0] bw_row(input logic [M-1:0] mcand,
                                          input logic         mbit,
                                          input logic         is_last);
    logic [M-1:0] row;
    row = mcand & {M{mbit}};
    if (is_last) row[M-2:0] = ~row[M-2:0];
    else         row[M-1]   = ~row[M-1];
    return row;
  endfunction

  assign last_row    = (cnt_q == LAST_ROW);
  assign row_shifted = {{M{1'b0}}, bw_row(a_q, b_q[cnt_q], last_row)} << cnt_q;
  assign acc_sum     = acc_q + row_shifted;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_row)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath: capture with the correction constant preloaded, then one row per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      p_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            acc_q <= CORR;
            cnt_q <= '0;
          end
        end
        RUN: begin
          acc_q <= acc_sum;
          cnt_q <= cnt_q + 1'b1;
          if (last_row) p_q <= $signed(acc_sum);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q == RUN) || (state_q == DONE);
  assign bus.done = (state_q == DONE);
  assign bus.p    = p_q;

endmodule

// File: tb/tb_seq_bw_mult_ctrl.sv
// Randomized bench for seq_bw_mult_ctrl checked against a plain signed-product model.
module tb_seq_bw_mult_ctrl;
  localparam int M  = 5;
  localparam int PW = 2 * M;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [PW-1:0] last_p;

  seq_bw_mult_ctrl_if #(.M(M)) bus ();

  seq_bw_mult_ctrl #(.M(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] ref_prod(input logic [M-1:0] x, input logic [M-1:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    return PW'(sx * sy);
  endfunction

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One multiply starting now; during RUN the operands and start are scrambled.
  task automatic run_mult(input logic [M-1:0] av, input logic [M-1:0] bv, input bit hold);
    logic [PW-1:0] exp_p;
    exp_p     = ref_prod(av, bv);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk); #1;
    for (int k = 1; k <= M; k++) begin
      bus.start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      bus.a     = M'($urandom);
      bus.b     = M'($urandom);
      chk("busy_run", PW'(bus.busy), PW'(1));
      chk("done_early", PW'(bus.done), PW'(0));
      chk("p_hold", bus.p, last_p);
      @(posedge clk); #1;
    end
    chk("done_pulse", PW'(bus.done), PW'(1));
    chk("busy_done", PW'(bus.busy), PW'(1));
    chk("product", bus.p, exp_p);
    last_p    = exp_p;
    bus.start = hold ? 1'b1 : 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    chk("done_clear", PW'(bus.done), PW'(0));
    chk("busy_clear", PW'(bus.busy), PW'(0));
    chk("p_after", bus.p, exp_p);
    if (!hold) bus.start = 1'b0;
  endtask

  initial begin
    logic [M-1:0] da [10];
    logic [M-1:0] db [10];
    n_vec     = 0;
    n_err     = 0;
    last_p    = '0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b0;
    #2;
    chk("rst_busy", PW'(bus.busy), PW'(0));
    chk("rst_done", PW'(bus.done), PW'(0));
    chk("rst_p", bus.p, PW'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", PW'(bus.busy), PW'(0));

    da = '{5'd7, 5'h10, 5'h10, 5'd0, 5'h1F, 5'd15, 5'd1, 5'h10, 5'h0F, 5'h11};
    db = '{5'h1D, 5'h10, 5'd15, 5'h1F, 5'h1F, 5'd15, 5'h10, 5'd1, 5'h10, 5'h11};
    for (int i = 0; i < 10; i++) begin
      run_mult(da[i], db[i], 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    // start held high: products back to back, one per M+2 cycles
    for (int i = 0; i < 12; i++) run_mult(M'($urandom), M'($urandom), 1'b1);
    bus.start = 1'b0;
    @(posedge clk); #1;

    // abort during the third RUN cycle
    bus.start = 1'b1;
    bus.a     = 5'd9;
    bus.b     = 5'd11;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_busy", PW'(bus.busy), PW'(0));
    chk("abort_done", PW'(bus.done), PW'(0));
    chk("abort_p", bus.p, PW'(0));
    last_p = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < M + 2; k++) begin
      @(posedge clk); #1;
      chk("abort_nodone", PW'(bus.done), PW'(0));
    end
    run_mult(5'd3, 5'd2, 1'b0);
    chk("abort_next", bus.p, PW'(6));

    // every operand pair, alternating held start and random gaps
    for (int i = 0; i < (1 << (2*M)); i++) begin
      run_mult(M'(i >> M), M'(i), bit'(i[0]));
      if (!i[0]) repeat ($urandom_range(0, 1)) @(posedge clk);
      #0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
